// File: rtl/uart_apb_master_pkg.sv
// uart_apb_master_pkg: shared state, response type and counter width for the APB3 initiator
package uart_apb_master_pkg;
  localparam int APB_MST_TMO_CW = 16;
  localparam int APB_MST_DW = 32;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_mst_state_t;
  typedef struct packed {
    logic [APB_MST_DW-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_mst_rsp_t;
endpackage

// File: rtl/uart_apb_master_tmo.sv
// uart_apb_master_tmo: ACCESS wait counter, expired on the LIMIT-th cycle with PREADY low
module uart_apb_master_tmo
  import uart_apb_master_pkg::*;
#(
  parameter int unsigned LIMIT = 256
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expired
);
  logic [APB_MST_TMO_CW-1:0] r_cnt;
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  end
  assign o_expired = r_cnt == APB_MST_TMO_CW'(LIMIT - 1);
endmodule

// File: rtl/uart_apb_master.sv
// uart_apb_master: APB3 initiator for a single-outstanding cmd/rsp handshake; access timeout via UART_APB_MASTER_TIMEOUT_EN
module uart_apb_master
  import uart_apb_master_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      i_apb_pclk,
  input  logic                      i_apb_preset,
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic                      i_cmd_write,
  input  logic [APB_ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [APB_DATA_WIDTH-1:0] i_cmd_wdata,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                      o_rsp_err,
  output logic                      o_rsp_timeout,
  output logic [APB_ADDR_WIDTH-1:0] o_apb_paddr,
  output logic [APB_DATA_WIDTH-1:0] o_apb_pwdata,
  output logic                      o_apb_pwrite,
  output logic                      o_apb_psel,
  output logic                      o_apb_penable,
  input  logic [APB_DATA_WIDTH-1:0] i_apb_prdata,
  input  logic                      i_apb_pready,
  input  logic                      i_apb_pslverr
);
  apb_mst_state_t r_state;
  apb_mst_rsp_t   r_rsp;
  logic           w_tmo;
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 || APB_DATA_WIDTH > APB_MST_DW) begin : g_bad_cfg
    $error("uart_apb_master: illegal parameter value");
  end
`ifdef UART_APB_MASTER_TIMEOUT_EN
  uart_apb_master_tmo #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .i_clk     (i_apb_pclk),
    .i_rst     (i_apb_preset),
    .i_en      (r_state == ACCESS && !i_apb_pready),
    .i_clr     (r_state == SETUP),
    .o_expired (w_tmo)
  );
`else
  assign w_tmo = 1'b0;
`endif
  assign o_cmd_ready   = r_state == IDLE;
  assign o_rsp_rdata   = r_rsp.rdata[APB_DATA_WIDTH-1:0];
  assign o_rsp_err     = r_rsp.err;
  assign o_rsp_timeout = r_rsp.timeout;
  always_ff @(posedge i_apb_pclk) begin
    if (i_apb_preset) begin
      r_state       <= IDLE;
      r_rsp         <= '0;
      o_rsp_valid   <= 1'b0;
      o_apb_paddr   <= '0;
      o_apb_pwdata  <= '0;
      o_apb_pwrite  <= 1'b0;
      o_apb_psel    <= 1'b0;
      o_apb_penable <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_cmd_valid) begin
          o_apb_paddr  <= i_cmd_addr;
          o_apb_pwrite <= i_cmd_write;
          o_apb_pwdata <= i_cmd_write ? i_cmd_wdata : '0;
          o_apb_psel   <= 1'b1;
          r_state      <= SETUP;
        end
        SETUP: begin
          o_apb_penable <= 1'b1;
          r_state       <= ACCESS;
        end
        ACCESS: if (i_apb_pready || w_tmo) begin
          // a slave completing on the limit cycle takes priority over the timeout
          r_rsp.rdata   <= (i_apb_pready && !o_apb_pwrite && !i_apb_pslverr) ? APB_MST_DW'(i_apb_prdata) : '0;
          r_rsp.err     <= i_apb_pready ? i_apb_pslverr : 1'b1;
          r_rsp.timeout <= !i_apb_pready;
          o_rsp_valid   <= 1'b1;
          o_apb_psel    <= 1'b0;
          o_apb_penable <= 1'b0;
          r_state       <= RESP;
        end
        RESP: if (i_rsp_ready) begin
          o_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_apb_master.sv
// tb_uart_apb_master: scoreboard bench for the APB3 initiator with a programmable-wait slave model
module tb_uart_apb_master;
  import uart_apb_master_pkg::*;
  logic        clk = 1'b0;
  logic        i_apb_preset, i_cmd_valid, i_cmd_write, i_rsp_ready;
  logic [31:0] i_cmd_addr, i_cmd_wdata, i_apb_prdata;
  logic        i_apb_pready, i_apb_pslverr;
  logic        o_cmd_ready, o_rsp_valid, o_rsp_err, o_rsp_timeout;
  logic [31:0] o_rsp_rdata, o_apb_paddr, o_apb_pwdata;
  logic        o_apb_pwrite, o_apb_psel, o_apb_penable;
  int          total = 0, bad = 0, cyc = 0;
  int          s_wait = 0, s_cnt = 0;
  logic [31:0] s_rdata = '0;
  logic        s_err = 1'b0;
  apb_mst_rsp_t sb[$];
  apb_mst_rsp_t exp_rsp;

  uart_apb_master #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .i_apb_pclk(clk), .i_apb_preset(i_apb_preset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err(o_rsp_err), .o_rsp_timeout(o_rsp_timeout),
    .o_apb_paddr(o_apb_paddr), .o_apb_pwdata(o_apb_pwdata), .o_apb_pwrite(o_apb_pwrite),
    .o_apb_psel(o_apb_psel), .o_apb_penable(o_apb_penable),
    .i_apb_prdata(i_apb_prdata), .i_apb_pready(i_apb_pready), .i_apb_pslverr(i_apb_pslverr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // slave model: PREADY after s_wait low cycles; junk on PREADY/PRDATA/PSLVERR outside ACCESS
  always @(negedge clk) begin
    if (o_apb_psel && o_apb_penable) begin
      i_apb_pready  = s_cnt >= s_wait;
      i_apb_prdata  = s_rdata;
      i_apb_pslverr = s_err;
      s_cnt++;
    end else begin
      i_apb_pready  = 1'b1;
      i_apb_prdata  = 32'hBAD0_BAD0;
      i_apb_pslverr = 1'b1;
      s_cnt = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    while (!o_cmd_ready && n < 50) begin step(); n++; end
    i_cmd_valid = 1'b1; i_cmd_write = w; i_cmd_addr = a; i_cmd_wdata = d;
    step();
    i_cmd_valid = 1'b0; i_cmd_write = $urandom; i_cmd_addr = $urandom; i_cmd_wdata = $urandom;
  endtask

  task automatic wait_rsp(input logic [31:0] a, output int lat, output int en, output logic stable);
    lat = 0; en = 0; stable = 1'b1;
    while (!o_rsp_valid && lat < 300) begin
      if (o_apb_penable) en++;
      if (o_apb_psel && o_apb_paddr !== a) stable = 1'b0;
      step();
      lat++;
    end
  endtask

  task automatic release_rsp();
    i_rsp_ready = 1'b1;
    step();
    i_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_apb_preset = 1'b1;
    step(); step();
    i_apb_preset = 1'b0;
    total++;
    if ({o_cmd_ready, o_rsp_valid, o_apb_psel, o_apb_penable, o_apb_pwrite, o_rsp_err, o_rsp_timeout} !== 7'b1000000
        || o_apb_paddr !== 0 || o_apb_pwdata !== 0 || o_rsp_rdata !== 0) begin
      bad++;
      $display("FAIL reset_state: rdy=%b vld=%b sel=%b en=%b addr=%h rdata=%h want rdy=1 others 0",
               o_cmd_ready, o_rsp_valid, o_apb_psel, o_apb_penable, o_apb_paddr, o_rsp_rdata);
    end
  endtask

  task automatic test_write();
    int lat, en;
    logic st;
    s_wait = 0; s_rdata = 32'hDEAD_BEEF; s_err = 1'b0;
    sb.push_back('{rdata: 32'h0, err: 1'b0, timeout: 1'b0});
    send(1'b1, 32'h4, 32'hA5A5_0001);
    total++;
    if ({o_apb_psel, o_apb_penable, o_apb_pwrite, o_cmd_ready} !== 4'b1010 || o_apb_paddr !== 32'h4 || o_apb_pwdata !== 32'hA5A5_0001) begin
      bad++;
      $display("FAIL write_setup: sel=%b en=%b wr=%b rdy=%b addr=%h wdata=%h want 1/0/1/0 4 a5a50001",
               o_apb_psel, o_apb_penable, o_apb_pwrite, o_cmd_ready, o_apb_paddr, o_apb_pwdata);
    end
    wait_rsp(32'h4, lat, en, st);
    total++;
    if (lat !== 2 || en !== 1) begin bad++; $display("FAIL write_latency: lat=%0d en=%0d want 2 1", lat, en); end
    total++;
    if (o_apb_psel !== 1'b0 || o_apb_penable !== 1'b0) begin bad++; $display("FAIL write_idle_bus: sel=%b en=%b want 0 0", o_apb_psel, o_apb_penable); end
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL write_rsp: no expected entry"); end
    else begin
      exp_rsp = sb.pop_front();
      if ({o_rsp_rdata, o_rsp_err, o_rsp_timeout} !== exp_rsp) begin
        bad++; $display("FAIL write_rsp: got %h/%b/%b want %h/%b/%b", o_rsp_rdata, o_rsp_err, o_rsp_timeout, exp_rsp.rdata, exp_rsp.err, exp_rsp.timeout);
      end
    end
    release_rsp();
    total++;
    if (o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b1 || o_apb_paddr !== 32'h4) begin
      bad++; $display("FAIL write_release: vld=%b rdy=%b addr=%h want 0 1 4", o_rsp_valid, o_cmd_ready, o_apb_paddr);
    end
  endtask

  task automatic test_read_wait();
    int lat, en;
    logic st;
    s_wait = 3; s_rdata = 32'h0000_00C3; s_err = 1'b0;
    sb.push_back('{rdata: 32'hC3, err: 1'b0, timeout: 1'b0});
    send(1'b0, 32'h8, 32'hFFFF_FFFF);
    total++;
    if (o_apb_pwrite !== 1'b0 || o_apb_pwdata !== 32'h0) begin bad++; $display("FAIL read_pwdata: wr=%b wdata=%h want 0 0", o_apb_pwrite, o_apb_pwdata); end
    wait_rsp(32'h8, lat, en, st);
    total++;
    if (lat !== 5 || en !== 4 || st !== 1'b1) begin bad++; $display("FAIL read_wait_timing: lat=%0d en=%0d stable=%b want 5 4 1", lat, en, st); end
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL read_rsp: no expected entry"); end
    else begin
      exp_rsp = sb.pop_front();
      if ({o_rsp_rdata, o_rsp_err, o_rsp_timeout} !== exp_rsp) begin
        bad++; $display("FAIL read_rsp: got %h/%b/%b want %h/%b/%b", o_rsp_rdata, o_rsp_err, o_rsp_timeout, exp_rsp.rdata, exp_rsp.err, exp_rsp.timeout);
      end
    end
    release_rsp();
  endtask

  task automatic test_slverr();
    int lat, en;
    logic st;
    s_rdata = 32'h1234_5678; s_err = 1'b1;
    for (int k = 0; k < 2; k++) begin
      s_wait = k;
      sb.push_back('{rdata: 32'h0, err: 1'b1, timeout: 1'b0});
      send(k[0], 32'h10 + k, 32'h5555_0000);
      wait_rsp(32'h10 + k, lat, en, st);
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL slverr_rsp: no expected entry"); end
      else begin
        exp_rsp = sb.pop_front();
        if (lat >= 300 || {o_rsp_rdata, o_rsp_err, o_rsp_timeout} !== exp_rsp) begin
          bad++; $display("FAIL slverr_rsp%0d: lat=%0d got %h/%b/%b want %h/%b/%b", k, lat, o_rsp_rdata, o_rsp_err, o_rsp_timeout, exp_rsp.rdata, exp_rsp.err, exp_rsp.timeout);
        end
      end
      release_rsp();
    end
    s_err = 1'b0;
  endtask

  task automatic test_timeout();
    int lat, en;
    logic st;
    s_wait = 100000;
`ifdef UART_APB_MASTER_TIMEOUT_EN
    sb.push_back('{rdata: 32'h0, err: 1'b1, timeout: 1'b1});
    send(1'b0, 32'h40, 32'h0);
    wait_rsp(32'h40, lat, en, st);
    total++;
    if (lat !== 9 || en !== 8) begin bad++; $display("FAIL timeout_timing: lat=%0d en=%0d want 9 8", lat, en); end
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL timeout_rsp: no expected entry"); end
    else begin
      exp_rsp = sb.pop_front();
      if ({o_rsp_rdata, o_rsp_err, o_rsp_timeout, o_apb_psel, o_apb_penable} !== {exp_rsp, 2'b00}) begin
        bad++; $display("FAIL timeout_rsp: got %h/%b/%b sel=%b en=%b want %h/%b/%b sel=0 en=0", o_rsp_rdata, o_rsp_err, o_rsp_timeout, o_apb_psel, o_apb_penable, exp_rsp.rdata, exp_rsp.err, exp_rsp.timeout);
      end
    end
    release_rsp();
`else
    send(1'b0, 32'h40, 32'h0);
    st = 1'b1;
    for (int i = 0; i < 120; i++) begin
      step();
      if (!(o_apb_psel && o_apb_penable) || o_rsp_valid) st = 1'b0;
    end
    total++;
    if (st !== 1'b1) begin bad++; $display("FAIL no_timeout_hold: sel=%b en=%b vld=%b want 1 1 0 for 120 cycles", o_apb_psel, o_apb_penable, o_rsp_valid); end
    i_apb_preset = 1'b1;
    step();
    i_apb_preset = 1'b0;
`endif
    s_wait = 0;
  endtask

  task automatic test_rsp_hold();
    int lat, en;
    logic st;
    s_wait = 0; s_rdata = 32'h5A5A_0F0F; s_err = 1'b0;
    sb.push_back('{rdata: 32'h5A5A_0F0F, err: 1'b0, timeout: 1'b0});
    send(1'b0, 32'h18, 32'h0);
    wait_rsp(32'h18, lat, en, st);
    exp_rsp = sb.size() != 0 ? sb.pop_front() : '0;
    i_cmd_valid = 1'b1; i_cmd_write = 1'b1; i_cmd_addr = 32'h20; i_cmd_wdata = 32'h1111_2222;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (o_rsp_valid !== 1'b1 || o_cmd_ready !== 1'b0 || {o_rsp_rdata, o_rsp_err, o_rsp_timeout} !== exp_rsp) begin
        bad++; $display("FAIL hold_stable%0d: vld=%b rdy=%b rdata=%h err=%b want 1 0 %h %b", i, o_rsp_valid, o_cmd_ready, o_rsp_rdata, o_rsp_err, exp_rsp.rdata, exp_rsp.err);
      end
      step();
    end
    sb.push_back('{rdata: 32'h0, err: 1'b0, timeout: 1'b0});
    release_rsp();
    total++;
    if (o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b1 || o_apb_psel !== 1'b0) begin
      bad++; $display("FAIL hold_release: vld=%b rdy=%b sel=%b want 0 1 0", o_rsp_valid, o_cmd_ready, o_apb_psel);
    end
    step();
    i_cmd_valid = 1'b0;
    total++;
    if (o_apb_psel !== 1'b1 || o_apb_paddr !== 32'h20 || o_apb_pwdata !== 32'h1111_2222) begin
      bad++; $display("FAIL hold_second_accept: sel=%b addr=%h wdata=%h want 1 20 11112222", o_apb_psel, o_apb_paddr, o_apb_pwdata);
    end
    wait_rsp(32'h20, lat, en, st);
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL hold_second_rsp: no expected entry"); end
    else begin
      exp_rsp = sb.pop_front();
      if (lat !== 2 || {o_rsp_rdata, o_rsp_err, o_rsp_timeout} !== exp_rsp) begin
        bad++; $display("FAIL hold_second_rsp: lat=%0d got %h/%b/%b want 2 %h/%b/%b", lat, o_rsp_rdata, o_rsp_err, o_rsp_timeout, exp_rsp.rdata, exp_rsp.err, exp_rsp.timeout);
      end
    end
    release_rsp();
  endtask

  task automatic test_back_to_back();
    int t[4];
    int n;
    s_wait = 0; s_err = 1'b0;
    i_rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while ((k == 4 ? !o_rsp_valid : !o_cmd_ready) && n < 20) begin
        step(); n++;
        if (o_rsp_valid && k < 4) begin
          total++;
          exp_rsp = sb.size() != 0 ? sb.pop_front() : '1;
          if ({o_rsp_rdata, o_rsp_err, o_rsp_timeout} !== exp_rsp) begin
            bad++; $display("FAIL b2b_rsp: got %h/%b/%b want %h/%b/%b", o_rsp_rdata, o_rsp_err, o_rsp_timeout, exp_rsp.rdata, exp_rsp.err, exp_rsp.timeout);
          end
        end
      end
      if (k == 4) break;
      t[k] = cyc;
      s_rdata = 32'hC0DE_0000 + k;
      sb.push_back('{rdata: 32'hC0DE_0000 + k, err: 1'b0, timeout: 1'b0});
      send(1'b0, 32'h100 + 4 * k, 32'h0);
    end
    total++;
    exp_rsp = sb.size() != 0 ? sb.pop_front() : '1;
    if (o_rsp_valid !== 1'b1 || {o_rsp_rdata, o_rsp_err, o_rsp_timeout} !== exp_rsp) begin
      bad++; $display("FAIL b2b_last_rsp: vld=%b got %h want %h", o_rsp_valid, o_rsp_rdata, exp_rsp.rdata);
    end
    step();
    i_rsp_ready = 1'b0;
    for (int k = 1; k < 4; k++) begin
      total++;
      if (t[k] - t[k-1] !== 4) begin bad++; $display("FAIL b2b_spacing%0d: got %0d want 4 cycles", k, t[k] - t[k-1]); end
    end
  endtask

  task automatic test_reset_mid();
    logic st;
    s_wait = 100000; s_rdata = 32'h7777_7777;
    send(1'b0, 32'h44, 32'h0);
    step(); step(); step();
    i_apb_preset = 1'b1;
    step();
    i_apb_preset = 1'b0;
    total++;
    if ({o_apb_psel, o_apb_penable, o_rsp_valid, o_cmd_ready} !== 4'b0001 || o_apb_paddr !== 32'h0) begin
      bad++; $display("FAIL reset_mid: sel=%b en=%b vld=%b rdy=%b addr=%h want 0 0 0 1 0", o_apb_psel, o_apb_penable, o_rsp_valid, o_cmd_ready, o_apb_paddr);
    end
    s_wait = 0;
    i_rsp_ready = 1'b1;
    st = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_rsp_valid || o_apb_psel) st = 1'b0;
    end
    i_rsp_ready = 1'b0;
    total++;
    if (st !== 1'b1) begin bad++; $display("FAIL reset_no_stale: stale response or bus activity after reset"); end
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size()); end
  endtask

  initial begin
    i_apb_preset = 1'b1; i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_addr = '0; i_cmd_wdata = '0;
    i_rsp_ready = 1'b0; i_apb_prdata = '0; i_apb_pready = 1'b0; i_apb_pslverr = 1'b0;
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_rsp_hold();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
